// File: rtl/cordic_scheduler.sv
// rtl/cordic_scheduler.sv - round-robin scheduler sharing one CORDIC convergence + iterative datapath
module cordic_scheduler #(
    parameter int N_FRAC = 7,
    parameter int N_ITER = 8,
    parameter int IDX_W  = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_valid_i,
    input  logic [N_FRAC:0]     req0_x_i,
    input  logic [N_FRAC:0]     req0_y_i,
    input  logic [N_FRAC:0]     req0_z_i,
    output logic                req0_ready_o,
    input  logic                req1_valid_i,
    input  logic [N_FRAC:0]     req1_x_i,
    input  logic [N_FRAC:0]     req1_y_i,
    input  logic [N_FRAC:0]     req1_z_i,
    output logic                req1_ready_o,
    output logic [N_FRAC:0]     conv_x_o,
    output logic [N_FRAC:0]     conv_y_o,
    output logic [N_FRAC:0]     conv_z_o,
    output logic                conv_strobe_o,
    input  logic                conv_strobe_i,
    output logic                iter_load_o,
    output logic                iter_en_o,
    output logic [IDX_W-1:0]    iter_idx_o,
    output logic                done_strobe_o,
    output logic                done_id_o,
    output logic                busy_o
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITER - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CONV,
        ITERATE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_id_q, grant_id_d;
    logic [N_FRAC:0]    x_q, x_d, y_q, y_d, z_q, z_d;
    logic               conv_strobe_q, conv_strobe_d;
    logic               iter_en_q, iter_en_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_strobe_q, done_strobe_d;
    logic               done_id_q, done_id_d;
    logic               busy_q, busy_d;
    logic               win0, win1;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        win0 = req0_valid_i && (!req1_valid_i || last_grant_q);
        win1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
    end

    assign req0_ready_o = rst_i && (state_q == IDLE) && win0;
    assign req1_ready_o = rst_i && (state_q == IDLE) && win1;

    // The iterative stage must capture convergence results in the strobe cycle itself.
    assign iter_load_o  = (state_q == WAIT_CONV) && conv_strobe_i;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        x_d           = x_q;
        y_d           = y_q;
        z_d           = z_q;
        conv_strobe_d = 1'b0;
        iter_en_d     = iter_en_q;
        idx_d         = idx_q;
        done_strobe_d = 1'b0;
        done_id_d     = done_id_q;
        busy_d        = busy_q;
        case (state_q)
            IDLE: begin
                if (req0_ready_o || req1_ready_o) begin
                    x_d           = req1_ready_o ? req1_x_i : req0_x_i;
                    y_d           = req1_ready_o ? req1_y_i : req0_y_i;
                    z_d           = req1_ready_o ? req1_z_i : req0_z_i;
                    grant_id_d    = req1_ready_o;
                    last_grant_d  = req1_ready_o;
                    conv_strobe_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_CONV;
            end
            WAIT_CONV: begin
                if (conv_strobe_i) begin
                    iter_en_d = 1'b1;
                    idx_d     = '0;
                    state_d   = ITERATE;
                end
            end
            ITERATE: begin
                if (idx_q == LAST_IDX) begin
                    iter_en_d     = 1'b0;
                    idx_d         = '0;
                    done_strobe_d = 1'b1;
                    done_id_d     = grant_id_q;
                    state_d       = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                x_d     = '0;
                y_d     = '0;
                z_d     = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            grant_id_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            conv_strobe_q <= 1'b0;
            iter_en_q     <= 1'b0;
            idx_q         <= '0;
            done_strobe_q <= 1'b0;
            done_id_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            x_q           <= x_d;
            y_q           <= y_d;
            z_q           <= z_d;
            conv_strobe_q <= conv_strobe_d;
            iter_en_q     <= iter_en_d;
            idx_q         <= idx_d;
            done_strobe_q <= done_strobe_d;
            done_id_q     <= done_id_d;
            busy_q        <= busy_d;
        end
    end

    assign conv_x_o      = x_q;
    assign conv_y_o      = y_q;
    assign conv_z_o      = z_q;
    assign conv_strobe_o = conv_strobe_q;
    assign iter_en_o     = iter_en_q;
    assign iter_idx_o    = idx_q;
    assign done_strobe_o = done_strobe_q;
    assign done_id_o     = done_id_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// tb/tb_cordic_scheduler.sv - directed self-checking bench for cordic_scheduler
module tb_cordic_scheduler;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req0_valid_i, req1_valid_i;
    logic [7:0] req0_x_i, req0_y_i, req0_z_i, req1_x_i, req1_y_i, req1_z_i;
    logic       req0_ready_o, req1_ready_o;
    logic [7:0] conv_x_o, conv_y_o, conv_z_o;
    logic       conv_strobe_o, conv_strobe_i, iter_load_o, iter_en_o;
    logic [2:0] iter_idx_o;
    logic       done_strobe_o, done_id_o, busy_o;

    always #5 clk_i = ~clk_i;

    cordic_scheduler #(.N_FRAC(7), .N_ITER(8), .IDX_W(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_x_i(req0_x_i), .req0_y_i(req0_y_i),
        .req0_z_i(req0_z_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_x_i(req1_x_i), .req1_y_i(req1_y_i),
        .req1_z_i(req1_z_i), .req1_ready_o(req1_ready_o),
        .conv_x_o(conv_x_o), .conv_y_o(conv_y_o), .conv_z_o(conv_z_o),
        .conv_strobe_o(conv_strobe_o), .conv_strobe_i(conv_strobe_i),
        .iter_load_o(iter_load_o), .iter_en_o(iter_en_o), .iter_idx_o(iter_idx_o),
        .done_strobe_o(done_strobe_o), .done_id_o(done_id_o), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit auto_conv = 1'b1, spur = 1'b0, spur_iter = 1'b0, conv_pend = 1'b0;
    bit drop0 = 1'b0, drop1 = 1'b0, pend0 = 1'b0, pend1 = 1'b0;
    int acc_cyc[$], acc_id[$], issue_cyc[$], load_cyc[$], en_cyc[$], en_idx[$];
    int done_cyc[$], done_ids[$];
    logic [7:0] iss_x[$], iss_y[$], iss_z[$];
    int bad_ready, busy_cnt;

    task automatic next_cycle();
        conv_pend = conv_strobe_o;
        @(posedge clk_i);
        #1;
        cyc++;
        if (pend0) begin req0_valid_i = 1'b0; pend0 = 1'b0; end
        if (pend1) begin req1_valid_i = 1'b0; pend1 = 1'b0; end
        conv_strobe_i = (auto_conv && conv_pend) || spur || (spur_iter && iter_en_o);
    endtask

    task automatic clear_log();
        acc_cyc.delete(); acc_id.delete(); issue_cyc.delete(); load_cyc.delete();
        en_cyc.delete(); en_idx.delete(); done_cyc.delete(); done_ids.delete();
        iss_x.delete(); iss_y.delete(); iss_z.delete();
        bad_ready = 0;
        busy_cnt = 0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            if (req0_valid_i && req0_ready_o) begin
                acc_cyc.push_back(cyc); acc_id.push_back(0); if (drop0) pend0 = 1'b1;
            end
            if (req1_valid_i && req1_ready_o) begin
                acc_cyc.push_back(cyc); acc_id.push_back(1); if (drop1) pend1 = 1'b1;
            end
            if (req0_ready_o && req1_ready_o) bad_ready++;
            if (busy_o && (req0_ready_o || req1_ready_o)) bad_ready++;
            if (busy_o) busy_cnt++;
            if (conv_strobe_o) begin
                issue_cyc.push_back(cyc); iss_x.push_back(conv_x_o);
                iss_y.push_back(conv_y_o); iss_z.push_back(conv_z_o);
            end
            if (iter_load_o) load_cyc.push_back(cyc);
            if (iter_en_o) begin en_cyc.push_back(cyc); en_idx.push_back(int'(iter_idx_o)); end
            if (done_strobe_o) begin done_cyc.push_back(cyc); done_ids.push_back(int'(done_id_o)); end
            next_cycle();
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        drop0 = 1'b0; drop1 = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        spur = 1'b0; spur_iter = 1'b0; auto_conv = 1'b1;
        next_cycle();
        next_cycle();
        rst_i = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_i = 1'b0; conv_strobe_i = 1'b0;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_x_i = 8'h11; req0_y_i = 8'h22; req0_z_i = 8'h33;
        req1_x_i = 8'h44; req1_y_i = 8'h55; req1_z_i = 8'h66;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if ({conv_strobe_o, iter_load_o, iter_en_o, iter_idx_o, done_strobe_o, done_id_o, busy_o} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {conv_strobe_o, iter_load_o, iter_en_o, iter_idx_o, done_strobe_o, done_id_o, busy_o});
        end
        checks++;
        if ({conv_x_o, conv_y_o, conv_z_o} !== 24'd0) begin
            errors++;
            $display("FAIL reset_conv got %h want 0", {conv_x_o, conv_y_o, conv_z_o});
        end
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b want 00", {req0_ready_o, req1_ready_o});
        end
        rst_i = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_job();
        int s;
        do_reset();
        clear_log();
        s = cyc;
        req0_x_i = 8'h40; req0_y_i = 8'h00; req0_z_i = 8'h50;
        req0_valid_i = 1'b1; drop0 = 1'b1;
        watch(14);
        checks++;
        if (acc_cyc.size() != 1 || acc_cyc[0] != s || acc_id[0] != 0) begin
            errors++; $display("FAIL single_accept got n=%0d want one at %0d", acc_cyc.size(), s);
        end
        checks++;
        if (issue_cyc.size() != 1 || issue_cyc[0] != s + 1) begin
            errors++; $display("FAIL single_issue got n=%0d want one at %0d", issue_cyc.size(), s + 1);
        end else begin
            checks++;
            if ({iss_x[0], iss_y[0], iss_z[0]} !== 24'h400050) begin
                errors++; $display("FAIL single_operands got %h want 400050", {iss_x[0], iss_y[0], iss_z[0]});
            end
        end
        checks++;
        if (load_cyc.size() != 1 || load_cyc[0] != s + 2) begin
            errors++; $display("FAIL single_load got n=%0d want one at %0d", load_cyc.size(), s + 2);
        end
        checks++;
        if (en_cyc.size() != 8) begin
            errors++; $display("FAIL single_en_count got %0d want 8", en_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (en_cyc[i] != s + 3 + i || en_idx[i] != i) begin
                    errors++; $display("FAIL single_idx got cyc %0d idx %0d want cyc %0d idx %0d", en_cyc[i], en_idx[i], s + 3 + i, i);
                end
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 11 || done_ids[0] != 0) begin
            errors++; $display("FAIL single_done got n=%0d want one at %0d id 0", done_cyc.size(), s + 11);
        end
        #1;
        checks++;
        if ({busy_o, conv_x_o, conv_z_o} !== 17'd0) begin
            errors++; $display("FAIL single_idle_after got %h want 0", {busy_o, conv_x_o, conv_z_o});
        end
        next_cycle();
    endtask

    task automatic test_contention();
        int s;
        do_reset();
        clear_log();
        s = cyc;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        watch(50);
        checks++;
        if (acc_cyc.size() < 4) begin
            errors++; $display("FAIL cont_accepts got %0d want >=4", acc_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_id[k] != (k % 2) || acc_cyc[k] != s + 12 * k) begin
                    errors++; $display("FAIL cont_grant got id %0d cyc %0d want id %0d cyc %0d", acc_id[k], acc_cyc[k], k % 2, s + 12 * k);
                end
            end
        end
        checks++;
        if (done_ids.size() != 4) begin
            errors++; $display("FAIL cont_done_count got %0d want 4", done_ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (done_ids[k] != (k % 2)) begin
                    errors++; $display("FAIL cont_done_id got %0d want %0d", done_ids[k], k % 2);
                end
            end
        end
        checks++;
        if (bad_ready != 0) begin
            errors++; $display("FAIL cont_loser_ready got %0d want 0", bad_ready);
        end
    endtask

    task automatic test_req1_only();
        int s;
        do_reset();
        clear_log();
        s = cyc;
        req1_x_i = 8'hC0; req1_y_i = 8'h20; req1_z_i = 8'hE0;
        req1_valid_i = 1'b1;
        watch(40);
        checks++;
        if (acc_cyc.size() != 4) begin
            errors++; $display("FAIL r1_accepts got %0d want 4", acc_cyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_id[k] != 1 || acc_cyc[k] != s + 12 * k) begin
                    errors++; $display("FAIL r1_grant got id %0d cyc %0d want id 1 cyc %0d", acc_id[k], acc_cyc[k], s + 12 * k);
                end
            end
        end
        checks++;
        if (iss_x.size() < 1 || {iss_x[0], iss_y[0], iss_z[0]} !== 24'hC020E0) begin
            errors++; $display("FAIL r1_operands got n=%0d want C020E0", iss_x.size());
        end
        checks++;
        if (done_ids.size() != 3 || done_ids[0] != 1 || done_ids[2] != 1) begin
            errors++; $display("FAIL r1_done got n=%0d want 3 with id 1", done_ids.size());
        end
    endtask

    task automatic test_delayed_conv();
        int s, l;
        do_reset();
        clear_log();
        auto_conv = 1'b0;
        s = cyc;
        req0_x_i = 8'h7F; req0_y_i = 8'h81; req0_z_i = 8'h01;
        req0_valid_i = 1'b1; drop0 = 1'b1;
        watch(2);
        checks++;
        if (issue_cyc.size() != 1 || issue_cyc[0] != s + 1) begin
            errors++; $display("FAIL dly_issue got n=%0d want one at %0d", issue_cyc.size(), s + 1);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({busy_o, iter_en_o, iter_load_o} !== 3'b100) begin
                errors++; $display("FAIL dly_wait got %b want 100", {busy_o, iter_en_o, iter_load_o});
            end
            next_cycle();
        end
        clear_log();
        conv_strobe_i = 1'b1;
        l = cyc;
        watch(11);
        checks++;
        if (load_cyc.size() != 1 || load_cyc[0] != l || l != s + 7) begin
            errors++; $display("FAIL dly_load got n=%0d at %0d want one at %0d", load_cyc.size(), l, s + 7);
        end
        checks++;
        if (en_cyc.size() != 8 || en_cyc[0] != l + 1 || en_idx[7] != 7) begin
            errors++; $display("FAIL dly_iter got n=%0d want 8 from %0d", en_cyc.size(), l + 1);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != l + 9) begin
            errors++; $display("FAIL dly_done got n=%0d want one at %0d", done_cyc.size(), l + 9);
        end
        auto_conv = 1'b1;
    endtask

    task automatic test_spurious();
        int s;
        do_reset();
        clear_log();
        spur = 1'b1;
        conv_strobe_i = 1'b1;
        watch(3);
        checks++;
        if (busy_cnt != 0 || load_cyc.size() != 0 || en_cyc.size() != 0 || issue_cyc.size() != 0) begin
            errors++; $display("FAIL spur_idle got busy %0d load %0d en %0d want 0", busy_cnt, load_cyc.size(), en_cyc.size());
        end
        spur = 1'b0;
        spur_iter = 1'b1;
        conv_strobe_i = 1'b0;
        clear_log();
        s = cyc;
        req0_valid_i = 1'b1; drop0 = 1'b1;
        watch(13);
        checks++;
        if (load_cyc.size() != 1 || load_cyc[0] != s + 2) begin
            errors++; $display("FAIL spur_load got n=%0d want one at %0d", load_cyc.size(), s + 2);
        end
        checks++;
        if (en_cyc.size() != 8) begin
            errors++; $display("FAIL spur_en_count got %0d want 8", en_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (en_idx[i] != i || en_cyc[i] != s + 3 + i) begin
                    errors++; $display("FAIL spur_idx got %0d want %0d", en_idx[i], i);
                end
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 11) begin
            errors++; $display("FAIL spur_done got n=%0d want one at %0d", done_cyc.size(), s + 11);
        end
        spur_iter = 1'b0;
    endtask

    task automatic test_mid_reset();
        int s;
        bit found;
        do_reset();
        req1_valid_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (iter_en_o && iter_idx_o == 3'd4) found = 1'b1;
            else next_cycle();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mreset_reach got no idx 4 want idx 4 within 20 cycles");
        end
        rst_i = 1'b0;
        req0_valid_i = 1'b1;
        next_cycle();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({conv_strobe_o, iter_load_o, iter_en_o, iter_idx_o, done_strobe_o, busy_o, conv_x_o} !== 16'd0) begin
            errors++; $display("FAIL mreset_outputs got %h want 0", {conv_strobe_o, iter_load_o, iter_en_o, iter_idx_o, done_strobe_o, busy_o, conv_x_o});
        end
        checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            errors++; $display("FAIL mreset_grant got %b want 10", {req0_ready_o, req1_ready_o});
        end
        clear_log();
        s = cyc;
        watch(12);
        checks++;
        if (acc_cyc.size() != 1 || acc_id[0] != 0) begin
            errors++; $display("FAIL mreset_accept got n=%0d want one id 0", acc_cyc.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 11 || done_ids[0] != 0) begin
            errors++; $display("FAIL mreset_done got n=%0d want one at %0d id 0", done_cyc.size(), s + 11);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_contention();
        test_req1_only();
        test_delayed_conv();
        test_spurious();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
